bitcol_sched_vert_8: RTL and testbench
======================================

Name: bitcol_sched_vert_8

Overview:
- Upstream issue stage for the vertical (bit-column) MAC unit.
- Accepts one group of 8 signed weights plus 8 signed activations and computes the activation sum.
- Walks the weight bit columns and issues one MAC command per cycle: mux selects, valids, column index, skip-zero/MSB flags, constant-multiplier controls, `en` and `load_accum`.
- Sparse columns, all-zero columns and all-ones low columns are compressed so that no column issue ever needs more than 4 selected activations.

Parameters:
- DATA_WIDTH, 8, activation and weight width (the column walk is defined for 8).
- VEC_LENGTH, 8, activations and weights per group (fixed 8).
- MUX_SEL_WIDTH, $clog2(VEC_LENGTH), width of each mux select.
- SUM_ACT_WIDTH, $clog2(VEC_LENGTH)+DATA_WIDTH, width of the activation sum.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  1  group offered.
- in_ready  out  1  group accepted when in_valid && in_ready.
- w_in  in  DATA_WIDTH x VEC_LENGTH  signed weights.
- act_in  in  DATA_WIDTH x VEC_LENGTH  signed activations.
- act  out  DATA_WIDTH x VEC_LENGTH  registered activations to the MAC.
- act_sel  out  MUX_SEL_WIDTH x VEC_LENGTH/2  mux k picks act[k+act_sel[k]].
- act_val  out  1 x VEC_LENGTH/2  mux lane valid.
- sum_act  out  SUM_ACT_WIDTH  signed sum of the 8 registered activations.
- mul_const  out  3  constant multiplier mask.
- is_shift_mul  out  1  shift the constant path by 3.
- column_idx  out  3  current bit column.
- is_msb  out  1  column 7 (negative weight).
- is_skip_zero  out  1  lanes carry weight-bit ones (1) or zeros (0).
- en  out  1  MAC issue strobe.
- load_accum  out  1  first issue of a group.
- group_done  out  1  last issue of a group.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0; in_ready=1; state IDLE.
  - Asserting reset mid-group drops the group, and no further `en` is issued.
- Accept: on accept, register act_in, sum_act (sign-extended sum, exact in 11 bits), the 8 column bit-vectors C[c][i]=w_in[i][c], and their popcounts P[c].
- Classification per column:
  - c=0..5 with P=8: "ones column", sent to the constant path.
  - Any c with P=0: skipped.
  - Everything else: "issue column".
- Constant-path masks:
  - M_lo = ones-mask of columns 0..2.
  - M_hi = ones-mask of columns 3..5.
- States:
  - IDLE
  - CLO: issue if M_lo≠0 — mul_const=M_lo, is_shift_mul=0, all act_val=0, is_skip_zero=1, column_idx=0, is_msb=0.
  - CHI: issue if M_hi≠0 — mul_const=M_hi, is_shift_mul=1, other fields as in CLO.
  - COLS: one issue per pending column, ascending c.
- Transition order: IDLE → CLO → CHI → COLS → IDLE. States with nothing to issue are passed through combinationally, so no bubble cycles.
- COLS issue fields: column_idx=c, is_msb=(c==7), mul_const=0, is_shift_mul=0.
- COLS selected set S:
  - P≤4: S = indices with bit 1, is_skip_zero=1.
  - P≥5: S = indices with bit 0, is_skip_zero=0.
  - |S|≤4 in both cases.
- Lane assignment, sorted S = s0<s1<…:
  - m_k = max(s_k−4, m_{k−1}+1), with m_{−1}=−1.
  - Lane m_k gets act_val=1 and act_sel=s_k−m_k (range 0..4).
  - Unused lanes: act_val=0, act_sel=0.
- All-zero group: exactly one issue with all act_val=0, mul_const=0, is_skip_zero=1, so the accumulator is still loaded.
- Per-group flags: load_accum=1 on the first issue of the group; group_done=1 on the last.
- Timing:
  - First issue in the cycle after accept; all outputs are registered.
  - Issue count N = [M_lo≠0] + [M_hi≠0] + number of issue columns, minimum 1.
  - in_ready=1 in IDLE and during the group_done cycle, so back-to-back groups issue with no gap.
  - act and sum_act hold their values until the next accept.
- `en` is 0 in every non-issue cycle; the other outputs hold their values.

Decomposition:
- Package bitcol_pkg holds: the state enum {IDLE, CLO, CHI, COLS}, the column-type constants, and the LANES=VEC_LENGTH/2 constant.
- One sub-module, lane_assign: combinational; takes an 8-bit set mask and produces act_sel/act_val per the greedy rule.

Test Plan:
- Weights all 0x00, acts 1..8 → exactly one issue with load_accum=group_done=1, act_val=0000, sum_act=36.
- Weights all 0x01 → one issue: mul_const=001, is_shift_mul=0, load_accum=group_done=1.
- Weights all 0x80 → one COLS issue at c=7: is_msb=1, is_skip_zero=0, act_val=0000.
- w[7]=0x02, others 0 → one issue at c=1, is_skip_zero=1; lane m0=3 gets act_val[3]=1, act_sel[3]=4.
- w[0..5]=0x10, w[6..7]=0 → one issue at c=4 (P=6 → zeros {6,7}) with is_skip_zero=0:
  - lane m0=2, act_sel=4;
  - lane m1=3, act_sel=4.
- Random groups accepted back-to-back → the issue count equals N for each group, with no gap cycles.
- Random groups with a golden model of the MAC's sum → accumulated value equals Σ w_i·a_i.
- Reset asserted mid-COLS → outputs 0 asynchronously and in_ready=1 after release.

Source files
------------

// File: rtl/bitcol_pkg.sv
// Shared types and helpers for the bit-column issue scheduler.
`default_nettype none

package bitcol_pkg;

    localparam int VEC   = 8;
    localparam int LANES = VEC / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLO  = 2'd1,
        CHI  = 2'd2,
        COLS = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COL_SKIP  = 2'd0,
        COL_ONES  = 2'd1,
        COL_ISSUE = 2'd2
    } col_type_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Only the low six columns may go to the constant path; column 7 is the sign.
    function automatic col_type_t classify(input int c, input logic [3:0] pop);
        if (pop == 4'd0) begin
            return COL_SKIP;
        end
        if (c <= 5 && pop == 4'd8) begin
            return COL_ONES;
        end
        return COL_ISSUE;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_assign.sv
// Greedy mapping of a selected-activation set (at most 4 members) onto 4 mux lanes.
`default_nettype none

module lane_assign
    import bitcol_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [7:0]             set_mask,
    output logic [LANES*SEL_W-1:0] act_sel,
    output logic [LANES-1:0]       act_val
);

    int prev;
    int m;

    // Lane m can reach act[m..m+4], so each member goes to the lowest lane that
    // both reaches it and lies above the previously used lane.
    always_comb begin
        act_sel = '0;
        act_val = '0;
        prev    = -1;
        m       = 0;
        for (int i = 0; i < 8; i++) begin
            if (set_mask[i]) begin
                m = ((i - 4) > (prev + 1)) ? (i - 4) : (prev + 1);
                if (m >= 0 && m < LANES) begin
                    act_val[m[1:0]]                      = 1'b1;
                    act_sel[m[1:0]*SEL_W +: SEL_W]       = SEL_W'(i - m);
                end
                prev = m;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bitcol_sched_vert_8.sv
// Issue stage for the vertical MAC: walks weight bit columns of one group and
// emits one registered MAC command per cycle.
`default_nettype none

module bitcol_sched_vert_8
    import bitcol_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 8,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH),
    parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0] w_in,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0] act_in,
    output logic [DATA_WIDTH*VEC_LENGTH-1:0] act,
    output logic [MUX_SEL_WIDTH*LANES-1:0]   act_sel,
    output logic [LANES-1:0]                 act_val,
    output logic [SUM_ACT_WIDTH-1:0]         sum_act,
    output logic [2:0]                       mul_const,
    output logic                             is_shift_mul,
    output logic [2:0]                       column_idx,
    output logic                             is_msb,
    output logic                             is_skip_zero,
    output logic                             en,
    output logic                             load_accum,
    output logic                             group_done
);

    state_t state;
    state_t nxt_state;

    logic [7:0] col_r [8];
    logic [3:0] pop_r [8];
    logic [2:0] hi_r;
    logic [7:0] pend_r;
    logic       hi_pend_r;

    logic [7:0]                      f_col [8];
    logic [3:0]                      f_pop [8];
    logic [7:0]                      f_ones;
    logic [2:0]                      f_lo;
    logic [2:0]                      f_hi;
    logic [7:0]                      f_pend;
    logic signed [SUM_ACT_WIDTH-1:0] f_sum;

    logic       accept;
    logic       issue;
    logic       fresh;
    logic       last;
    logic [2:0] cur_col;
    logic [7:0] nxt_pend;
    logic       nxt_hi_pend;

    logic [7:0]                     col_vec;
    logic [3:0]                     col_pop;
    logic                           col_skip;
    logic [7:0]                     set_mask;
    logic [2:0]                     nx_mul;
    logic                           nx_shift;
    logic [2:0]                     nx_col;
    logic                           nx_msb;
    logic                           nx_skip;
    logic                           nx_lanes;
    logic [MUX_SEL_WIDTH*LANES-1:0] la_sel;
    logic [LANES-1:0]               la_val;

    assign in_ready = (state == IDLE) || group_done;
    assign accept   = in_valid && in_ready;

    // Transpose the offered weights into bit columns and classify each column.
    always_comb begin
        f_ones = '0;
        f_pend = '0;
        f_sum  = '0;
        for (int c = 0; c < 8; c++) begin
            f_col[c] = '0;
            for (int i = 0; i < 8; i++) begin
                f_col[c][i] = w_in[i*DATA_WIDTH + c];
            end
            f_pop[c] = popcount8(f_col[c]);
            case (classify(c, f_pop[c]))
                COL_ONES:  f_ones[c] = 1'b1;
                COL_ISSUE: f_pend[c] = 1'b1;
                default:   ;
            endcase
        end
        for (int i = 0; i < VEC_LENGTH; i++) begin
            f_sum = f_sum + SUM_ACT_WIDTH'($signed(act_in[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    assign f_lo = f_ones[2:0];
    assign f_hi = f_ones[5:3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next issue: continue the stored group, else start a fresh one on accept.
    // Empty stages are skipped here so consecutive issues never leave a bubble.
    always_comb begin
        nxt_state   = IDLE;
        issue       = 1'b0;
        fresh       = 1'b0;
        cur_col     = 3'd0;
        nxt_pend    = pend_r;
        nxt_hi_pend = hi_pend_r;
        if (!in_ready) begin
            issue = 1'b1;
            if (hi_pend_r) begin
                nxt_state   = CHI;
                nxt_hi_pend = 1'b0;
            end else begin
                nxt_state         = COLS;
                cur_col           = lowest_idx(pend_r);
                nxt_pend[cur_col] = 1'b0;
            end
        end else if (accept) begin
            issue       = 1'b1;
            fresh       = 1'b1;
            nxt_pend    = f_pend;
            nxt_hi_pend = (f_hi != 3'd0);
            // An all-zero group still issues once through CLO with a zero mask.
            if (f_lo != 3'd0 || (f_hi == 3'd0 && f_pend == 8'd0)) begin
                nxt_state = CLO;
            end else if (f_hi != 3'd0) begin
                nxt_state   = CHI;
                nxt_hi_pend = 1'b0;
            end else begin
                nxt_state         = COLS;
                cur_col           = lowest_idx(f_pend);
                nxt_pend[cur_col] = 1'b0;
            end
        end
        last = issue && !nxt_hi_pend && (nxt_pend == 8'd0);
    end

    always_comb begin
        col_vec  = fresh ? f_col[cur_col] : col_r[cur_col];
        col_pop  = fresh ? f_pop[cur_col] : pop_r[cur_col];
        col_skip = (col_pop <= 4'd4);
        set_mask = col_skip ? col_vec : ~col_vec;
        nx_mul   = 3'd0;
        nx_shift = 1'b0;
        nx_col   = 3'd0;
        nx_msb   = 1'b0;
        nx_skip  = 1'b1;
        nx_lanes = 1'b0;
        case (nxt_state)
            CLO: nx_mul = f_lo;
            CHI: begin
                nx_mul   = fresh ? f_hi : hi_r;
                nx_shift = 1'b1;
            end
            COLS: begin
                nx_col   = cur_col;
                nx_msb   = (cur_col == 3'd7);
                nx_skip  = col_skip;
                nx_lanes = 1'b1;
            end
            default: ;
        endcase
    end

    lane_assign #(
        .SEL_W (MUX_SEL_WIDTH)
    ) u_lane_assign (
        .set_mask (set_mask),
        .act_sel  (la_sel),
        .act_val  (la_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act          <= '0;
            sum_act      <= '0;
            hi_r         <= '0;
            pend_r       <= '0;
            hi_pend_r    <= 1'b0;
            for (int c = 0; c < 8; c++) begin
                col_r[c] <= '0;
                pop_r[c] <= '0;
            end
            act_sel      <= '0;
            act_val      <= '0;
            mul_const    <= '0;
            is_shift_mul <= 1'b0;
            column_idx   <= '0;
            is_msb       <= 1'b0;
            is_skip_zero <= 1'b0;
            en           <= 1'b0;
            load_accum   <= 1'b0;
            group_done   <= 1'b0;
        end else begin
            en        <= issue;
            pend_r    <= nxt_pend;
            hi_pend_r <= nxt_hi_pend;
            if (fresh) begin
                act     <= act_in;
                sum_act <= f_sum;
                hi_r    <= f_hi;
                for (int c = 0; c < 8; c++) begin
                    col_r[c] <= f_col[c];
                    pop_r[c] <= f_pop[c];
                end
            end
            if (issue) begin
                act_sel      <= nx_lanes ? la_sel : '0;
                act_val      <= nx_lanes ? la_val : '0;
                mul_const    <= nx_mul;
                is_shift_mul <= nx_shift;
                column_idx   <= nx_col;
                is_msb       <= nx_msb;
                is_skip_zero <= nx_skip;
                load_accum   <= fresh;
                group_done   <= last;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitcol_sched_vert_8.sv
// Directed-vector and random-stream bench for bitcol_sched_vert_8 with a MAC model.
`default_nettype none

module tb_bitcol_sched_vert_8;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] w_in     = '0;
    logic [63:0] act_in   = '0;
    logic [63:0] act;
    logic [11:0] act_sel;
    logic [3:0]  act_val;
    logic [10:0] sum_act;
    logic [2:0]  mul_const;
    logic        is_shift_mul;
    logic [2:0]  column_idx;
    logic        is_msb;
    logic        is_skip_zero;
    logic        en;
    logic        load_accum;
    logic        group_done;

    bitcol_sched_vert_8 dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .w_in         (w_in),
        .act_in       (act_in),
        .act          (act),
        .act_sel      (act_sel),
        .act_val      (act_val),
        .sum_act      (sum_act),
        .mul_const    (mul_const),
        .is_shift_mul (is_shift_mul),
        .column_idx   (column_idx),
        .is_msb       (is_msb),
        .is_skip_zero (is_skip_zero),
        .en           (en),
        .load_accum   (load_accum),
        .group_done   (group_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int n;
        int dot;
    } exp_t;
    exp_t expq[$];

    typedef struct {
        logic [63:0] w;
        logic [63:0] a;
        logic [2:0]  mul;
        logic        shift;
        logic [2:0]  col;
        logic        msb;
        logic        skip;
        logic [3:0]  val;
        logic [11:0] sel;
        logic [10:0] sum;
        logic        done;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic int exp_n(input logic [63:0] w);
        int lo, hi, cnt, p;
        lo = 0; hi = 0; cnt = 0;
        for (int c = 0; c < 8; c++) begin
            p = 0;
            for (int i = 0; i < 8; i++) p += int'(w[i*8 + c]);
            if (p == 8 && c <= 5) begin
                if (c < 3) lo = 1; else hi = 1;
            end else if (p != 0) begin
                cnt++;
            end
        end
        return (lo + hi + cnt == 0) ? 1 : lo + hi + cnt;
    endfunction

    function automatic int exp_dot(input logic [63:0] w, input logic [63:0] a);
        int s;
        logic signed [7:0] wb, ab;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            wb = w[i*8 +: 8];
            ab = a[i*8 +: 8];
            s += int'(wb) * int'(ab);
        end
        return s;
    endfunction

    // Downstream MAC: lanes add selected activations, constant path scales the sum.
    function automatic int mac_partial();
        int lane_sum, sa, colp, cp, s;
        logic signed [7:0]  ab;
        logic signed [10:0] sas;
        lane_sum = 0;
        for (int k = 0; k < 4; k++) begin
            if (act_val[k]) begin
                s  = int'(act_sel[k*3 +: 3]);
                ab = act[(k + s)*8 +: 8];
                lane_sum += int'(ab);
            end
        end
        sas  = sum_act;
        sa   = int'(sas);
        colp = is_skip_zero ? lane_sum : sa - lane_sum;
        colp = colp * (1 << column_idx);
        if (is_msb) colp = -colp;
        cp = sa * int'(mul_const) * (is_shift_mul ? 8 : 1);
        return cp + colp;
    endfunction

    int   acc = 0;
    int   cnt = 0;
    bit   in_grp = 0;
    int   last_done_cycle = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!reset) begin
            in_grp = 0;
            expq.delete();
        end else if (en) begin
            if (load_accum) begin
                acc = mac_partial();
                cnt = 1;
                in_grp = 1;
            end else begin
                check("issue_inside_group", in_grp, 1);
                acc += mac_partial();
                cnt++;
            end
            check("ready_on_done", in_ready, group_done);
            if (group_done) begin
                last_done_cycle = cycle;
                if (expq.size() == 0) begin
                    check("unexpected_group", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("issue_count", cnt, e.n);
                    check("mac_result", acc, e.dot);
                end
                in_grp = 0;
            end
        end else if (in_grp) begin
            check("no_gap", en, 1);
        end
    end

    task automatic send_one(input logic [63:0] w, input logic [63:0] a);
        int bound;
        w_in     = w;
        act_in   = a;
        in_valid = 1'b1;
        bound    = 0;
        while (!in_ready && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 200) check("ready_timeout", 0, 1);
        expq.push_back('{exp_n(w), exp_dot(w, a)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    vec_t        tv[7];
    int          en_seen;
    int          cyc_start;
    int          sum_n;
    logic [63:0] rw, ra;
    logic [7:0]  om, zm;

    initial begin
        tv[0] = '{64'h0, 64'h0807060504030201, 3'b000, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0000, 12'h000, 11'd36, 1'b1};
        tv[1] = '{64'h0101010101010101, 64'h0807060504030201, 3'b001, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0000, 12'h000, 11'd36, 1'b1};
        tv[2] = '{64'h8080808080808080, 64'h8080808080808080, 3'b000, 1'b0, 3'd7, 1'b1, 1'b0, 4'b0000, 12'h000, 11'h400, 1'b1};
        tv[3] = '{64'h0200000000000000, 64'h7F7F7F7F7F7F7F7F, 3'b000, 1'b0, 3'd1, 1'b0, 1'b1, 4'b1000, 12'h800, 11'h3F8, 1'b1};
        tv[4] = '{64'h0000101010101010, 64'hF906FB04FD02FF00, 3'b000, 1'b0, 3'd4, 1'b0, 1'b0, 4'b1100, 12'h900, 11'h7FC, 1'b1};
        tv[5] = '{64'h0808080808080808, 64'h0101010101010101, 3'b001, 1'b1, 3'd0, 1'b0, 1'b1, 4'b0000, 12'h000, 11'd8, 1'b1};
        tv[6] = '{64'h0909090909090909, 64'h0807060504030201, 3'b001, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0000, 12'h000, 11'd36, 1'b0};

        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_en", en, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {act, sum_act, act_val, act_sel, mul_const, column_idx},
              '0);
        check("rst_flags", {load_accum, group_done, is_msb, is_skip_zero, is_shift_mul}, 5'b0);

        for (int v = 0; v < 7; v++) begin
            send_one(tv[v].w, tv[v].a);
            check($sformatf("v%0d_en", v), en, 1);
            check($sformatf("v%0d_load", v), load_accum, 1);
            check($sformatf("v%0d_done", v), group_done, tv[v].done);
            check($sformatf("v%0d_mul", v), {mul_const, is_shift_mul}, {tv[v].mul, tv[v].shift});
            check($sformatf("v%0d_col", v), {column_idx, is_msb, is_skip_zero},
                  {tv[v].col, tv[v].msb, tv[v].skip});
            check($sformatf("v%0d_lanes", v), {act_val, act_sel}, {tv[v].val, tv[v].sel});
            check($sformatf("v%0d_sum", v), sum_act, tv[v].sum);
            check($sformatf("v%0d_act", v), act, tv[v].a);
            repeat (12) @(negedge clk);
        end

        // Eight issue columns; reset lands on the third COLS issue.
        send_one(64'hAA55AA55AA55AA55, 64'h0807060504030201);
        repeat (2) @(negedge clk);
        check("midrst_pre_en", en, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_en", en, 0);
        check("midrst_outputs", {act, sum_act, act_val, column_idx}, '0);
        check("midrst_ready", in_ready, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        en_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (en) en_seen++;
        end
        check("midrst_no_en_after", en_seen, 0);
        check("midrst_ready_after", in_ready, 1);

        sum_n     = 0;
        cyc_start = cycle;
        for (int g = 0; g < 20; g++) begin
            om = 8'($urandom) & 8'h3F;
            if ($urandom_range(0, 1) == 0) om = 8'h00;
            zm = 8'($urandom) & ~om;
            if ($urandom_range(0, 1) == 0) zm = 8'h00;
            for (int i = 0; i < 8; i++) begin
                rw[i*8 +: 8] = (8'($urandom) | om) & ~zm;
                ra[i*8 +: 8] = 8'($urandom);
            end
            if (g % 7 == 3) rw = '0;
            sum_n += exp_n(rw);
            send_one(rw, ra);
        end
        repeat (15) @(negedge clk);
        check("stream_span", last_done_cycle - cyc_start, sum_n);
        check("all_groups_done", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
